// File: rtl/ram_bridge_if.sv
// CPU word bus plus 16-bit block-RAM port, grouped as seen by the bridge (slave)
// and by the CPU/RAM side driving it (master).
interface ram_bridge_if #(
    parameter int ADDRESS_WIDTH = 14
);
    logic                     cpu_valid;
    logic                     cpu_ready;
    logic [ADDRESS_WIDTH:0]   cpu_addr;
    logic [3:0]               cpu_wstrb;
    logic [31:0]              cpu_wdata;
    logic [31:0]              cpu_rdata;
    logic [1:0]               ram_we;
    logic [ADDRESS_WIDTH-1:0] ram_addr;
    logic [15:0]              ram_data;
    logic [15:0]              ram_q;

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, ram_q,
        output cpu_ready, cpu_rdata, ram_we, ram_addr, ram_data
    );

    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, cpu_wdata, ram_q,
        input  cpu_ready, cpu_rdata, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/ram_bridge.sv
// Splits each 32-bit CPU access into a low then high 16-bit RAM access and
// reassembles read data from the RAM's registered output.
//
// state | meaning
// IDLE  | waiting for cpu_valid; latches the request
// LO    | low-half RAM access presented
// HI    | high-half RAM access presented; low read half captured
// WAIT  | reads only: high read half captured
// ACK   | cpu_ready high for one cycle
module ram_bridge #(
    parameter int ADDRESS_WIDTH = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_bridge_if.slave  bus
);
    localparam int WORD_W = ADDRESS_WIDTH - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              lsb_q, lsb_d;

    logic [1:0]        ram_we_c;
    logic [15:0]       ram_data_c;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^bus.cpu_addr[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            wstrb_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            lsb_q   <= lsb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        lsb_d   = lsb_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_valid) begin
                    word_d  = bus.cpu_addr[ADDRESS_WIDTH:2];
                    wstrb_d = bus.cpu_wstrb;
                    wdata_d = bus.cpu_wdata;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                lsb_d   = 1'b0;
                state_d = S_HI;
            end
            S_HI: begin
                lsb_d = 1'b1;
                // ram_q here is the low-half result of the LO address
                if (wstrb_q == 4'b0000) begin
                    rdata_d[15:0] = bus.ram_q;
                    state_d       = S_WAIT;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_WAIT: begin
                rdata_d[31:16] = bus.ram_q;
                state_d        = S_ACK;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_ACK);
    end

    always_comb begin
        ram_we_c   = 2'b00;
        ram_data_c = wdata_q[15:0];
        case (state_q)
            S_LO: ram_we_c = wstrb_q[1:0];
            S_HI: begin
                ram_we_c   = wstrb_q[3:2];
                ram_data_c = wdata_q[31:16];
            end
            default: ram_we_c = 2'b00;
        endcase
    end

    // Outside LO/HI the address simply holds its last presented value
    assign bus.ram_addr  = {word_q, (state_q == S_LO) ? 1'b0 :
                                    (state_q == S_HI) ? 1'b1 : lsb_q};
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_data  = ram_data_c;
    assign bus.cpu_ready = ready_q;
    assign bus.cpu_rdata = rdata_q;
endmodule

// File: tb/tb_ram_bridge.sv
// Bench for ram_bridge: directed vector table, reset abort, then random traffic
// checked against a word-level memory model and a behavioural halfword RAM.
module tb_ram_bridge;
    localparam int AW = 14;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    ram_bridge_if #(.ADDRESS_WIDTH(AW)) bus ();

    ram_bridge #(.ADDRESS_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ram_mem [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<(AW-1))-1];
    logic [31:0] last_rd;

    always @(posedge clk) begin
        if (bus.ram_we[0]) ram_mem[bus.ram_addr][7:0]  <= bus.ram_data[7:0];
        if (bus.ram_we[1]) ram_mem[bus.ram_addr][15:8] <= bus.ram_data[15:8];
        bus.ram_q <= ram_mem[bus.ram_addr];
    end

    typedef struct {
        logic [14:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          b2b;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [14:0] a, input logic [3:0] s, input logic [31:0] d);
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wstrb = s;
        bus.cpu_wdata = d;
    endtask

    // Called at a negedge while the DUT is in IDLE; returns at the ACK negedge.
    task automatic do_req(input logic [14:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [13:0] lo_addr;
        int lat;
        lo_addr = {a[14:2], 1'b0};
        lat = -1;
        set_in(a, s, d);
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 1) begin
                chk("lo_addr", 32'(bus.ram_addr), 32'(lo_addr));
                chk("lo_we",   32'(bus.ram_we),   32'(s[1:0]));
                if (s != 4'b0000) chk("lo_data", 32'(bus.ram_data), 32'(d[15:0]));
                // Post-acceptance input changes must not leak into the access
                bus.cpu_addr  = 15'($urandom);
                bus.cpu_wstrb = 4'($urandom);
                bus.cpu_wdata = $urandom;
            end
            if (e == 2) begin
                chk("hi_addr", 32'(bus.ram_addr), 32'(lo_addr | 14'd1));
                chk("hi_we",   32'(bus.ram_we),   32'(s[3:2]));
                if (s != 4'b0000) chk("hi_data", 32'(bus.ram_data), 32'(d[31:16]));
            end
            if (e == 3 && s == 4'b0000) chk("wait_we", 32'(bus.ram_we), 32'd0);
            if (bus.cpu_ready) begin
                lat = e;
                break;
            end
        end
        chk("latency", 32'(lat), (s == 4'b0000) ? 32'd4 : 32'd3);
    endtask

    task automatic run_op(input logic [14:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [12:0] w;
        w = a[14:2];
        do_req(a, s, d);
        if (s == 4'b0000) begin
            chk("read_data", bus.cpu_rdata, ref_mem[w]);
            last_rd = ref_mem[w];
        end else begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
            chk("rdata_held", bus.cpu_rdata, last_rd);
        end
    endtask

    // From the ACK negedge: either present next request at once or idle first.
    task automatic gap(input bit b2b, input logic [14:0] a, input logic [3:0] s, input logic [31:0] d, input int extra);
        if (b2b) begin
            set_in(a, s, d);
            @(negedge clk);
            chk("single_pulse", 32'(bus.cpu_ready), 32'd0);
        end else begin
            bus.cpu_valid = 1'b0;
            @(negedge clk);
            chk("single_pulse", 32'(bus.cpu_ready), 32'd0);
            for (int k = 0; k <= extra; k++) @(negedge clk);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        last_rd = '0;
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        for (int i = 0; i < (1 << (AW - 1)); i++) ref_mem[i] = '0;

        tbl[0] = '{15'h0008, 4'hF,    32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1] = '{15'h0008, 4'h0,    32'h00000000, 32'hDEADBEEF, 1'b1};
        tbl[2] = '{15'h0008, 4'b0100, 32'h00AA0000, 32'hDEADBEEF, 1'b0};
        tbl[3] = '{15'h0008, 4'h0,    32'h00000000, 32'hDEAABEEF, 1'b1};
        tbl[4] = '{15'h7FFC, 4'hF,    32'h12345678, 32'hDEAABEEF, 1'b0};
        tbl[5] = '{15'h7FFC, 4'h0,    32'h00000000, 32'h12345678, 1'b0};
        tbl[6] = '{15'h0010, 4'b0110, 32'h11223344, 32'h12345678, 1'b1};
        tbl[7] = '{15'h0010, 4'h0,    32'h00000000, 32'h00223300, 1'b1};
        tbl[8] = '{15'h0003, 4'hF,    32'hCAFEF00D, 32'h00223300, 1'b0};
        tbl[9] = '{15'h0001, 4'h0,    32'h00000000, 32'hCAFEF00D, 1'b1};

        rst_n = 1'b0;
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wstrb = '0;
        bus.cpu_wdata = '0;
        #1;
        chk("rst_ready", 32'(bus.cpu_ready), 32'd0);
        chk("rst_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_we",    32'(bus.ram_we), 32'd0);
        chk("rst_addr",  32'(bus.ram_addr), 32'd0);
        chk("rst_data",  32'(bus.ram_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("idle_ready", 32'(bus.cpu_ready), 32'd0);
            chk("idle_we",    32'(bus.ram_we), 32'd0);
        end

        for (int i = 0; i < 10; i++) begin
            if (i > 0) gap(tbl[i].b2b, tbl[i].addr, tbl[i].wstrb, tbl[i].wdata, 0);
            run_op(tbl[i].addr, tbl[i].wstrb, tbl[i].wdata);
            chk($sformatf("vec%0d_rdata", i), bus.cpu_rdata, tbl[i].exp_rdata);
        end

        gap(1'b0, '0, '0, '0, 0);
        set_in(15'h0008, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_hi_addr", 32'(bus.ram_addr), 32'd5);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.cpu_ready), 32'd0);
        chk("abort_rdata", bus.cpu_rdata, 32'd0);
        chk("abort_we",    32'(bus.ram_we), 32'd0);
        last_rd = '0;
        bus.cpu_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_ready", 32'(bus.cpu_ready), 32'd0);
        end
        run_op(15'h0008, 4'h0, 32'h0);
        chk("after_abort_rdata", bus.cpu_rdata, 32'hDEAABEEF);

        for (int i = 0; i < 80; i++) begin
            logic [12:0] w;
            logic [14:0] a;
            logic [3:0]  s;
            int          pick;
            pick = int'($urandom_range(0, 15));
            w = (pick < 8) ? 13'(pick) : 13'(13'h1FF0 + pick);
            a = {w, 2'($urandom_range(0, 3))};
            s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            gap(bit'($urandom_range(0, 1)), a, s, $urandom, int'($urandom_range(0, 2)));
            run_op(a, s, bus.cpu_wdata);
        end

        bus.cpu_valid = 1'b0;
        @(negedge clk);
        chk("final_pulse", 32'(bus.cpu_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_bridge.md
# ram_bridge

Bridges the CPU's 32-bit valid/ready memory bus onto the 16-bit, byte-enabled, single-port block RAM, sitting directly upstream of the RAM. Every CPU word access becomes two RAM halfword accesses: low half first, high half second. Read data is reassembled from the RAM's registered output and returned with a one-cycle `cpu_ready` pulse.

## Interface
- `ADDRESS_WIDTH`, default 14: RAM halfword address width. It must match the RAM instance.
- `clk`  in  1  rising-edge clock, shared with the RAM.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cpu_valid`  in  1  request strobe; held by the CPU until `cpu_ready`.
- `cpu_ready`  out  1  completion pulse, exactly one cycle per request.
- `cpu_addr`  in  ADDRESS_WIDTH+1  byte address. Bits [1:0] are ignored; the word index is `cpu_addr[ADDRESS_WIDTH:2]`.
- `cpu_wstrb`  in  4  byte write strobes. All zero means read.
- `cpu_wdata`  in  32  write data.
- `cpu_rdata`  out  32  read data; valid while `cpu_ready`=1 and held until the next read completes.
- `ram_we`  out  2  RAM byte write enables ([0]=bits 7:0, [1]=bits 15:8).
- `ram_addr`  out  ADDRESS_WIDTH  RAM halfword address.
- `ram_data`  out  16  RAM write data.
- `ram_q`  in  16  RAM read data. It is registered and valid the cycle after its address is presented.

## Operation
- FSM states are IDLE, LO, HI, WAIT and ACK.
  - IDLE: if `cpu_valid`=1, latch `cpu_addr` word index, `cpu_wstrb` and `cpu_wdata` into request registers, then go to LO.
  - LO: present the low-half access, then go to HI.
  - HI: present the high-half access. Go to WAIT for a read, or to ACK for a write.
  - WAIT (reads only): go to ACK.
  - ACK: go to IDLE.
- RAM drive, taken combinationally from the state and the latched request only (never from live CPU inputs):
  - `ram_addr` = {word, 1'b0} in LO and {word, 1'b1} in HI. In other states the last value is held; it is don't-care.
  - `ram_we` = wstrb[1:0] in LO and wstrb[3:2] in HI. It is 2'b00 in all other states and 2'b00 for reads.
  - `ram_data` = wdata[15:0] in LO and wdata[31:16] in HI.
- Read capture, registered:
  - In HI, `ram_q` (the low-half result) is loaded into `cpu_rdata[15:0]`.
  - In WAIT, `ram_q` is loaded into `cpu_rdata[31:16]`.
  - Writes never modify `cpu_rdata`.
- `cpu_ready` is registered. It is 1 exactly while in ACK and 0 otherwise.
- Mixed strobes are written as given, e.g. wstrb=4'b0110 gives `ram_we`=2'b10 in LO and 2'b01 in HI. A write with one half's strobes zero still spends its LO/HI cycles with `ram_we`=0 for that half.
- Bus protocol: in the cycle after ACK the CPU either drops `cpu_valid` or presents a new request. IDLE accepts whatever is present then. There is no re-accept of the completed request, because ACK always passes through IDLE.
- Address wrap: the word index is taken modulo 2^(ADDRESS_WIDTH-1). Bits of the CPU address above `ADDRESS_WIDTH` are not ported and are decoded upstream.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `cpu_ready`=0, `cpu_rdata`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, request registers=0.
- Let edge 0 be the edge at which IDLE samples `cpu_valid`=1.
  - Write: LO in cycle 1, HI in cycle 2, `cpu_ready`=1 in cycle 3. Request-to-ready latency is 3 cycles.
  - Read: LO in cycle 1, HI in cycle 2, WAIT in cycle 3, `cpu_ready`=1 with full `cpu_rdata` in cycle 4. Latency is 4 cycles.
- Throughput is one request per 4 cycles (write) or 5 cycles (read), IDLE included.
- Changes to CPU inputs after acceptance have no effect until the next IDLE.
- Reset mid-transaction aborts the transaction and no `cpu_ready` is issued. A low-half write already committed in LO stays in RAM.

## Test plan
- Reset, then idle: all outputs 0; with `cpu_valid`=0 the block stays in IDLE, `ram_we`=0 indefinitely.
- Full-word write then read: write addr 0x0008, wstrb=4'hF, wdata 0xDEADBEEF. Required: `ram_we`=2'b11 at ram_addr 4 with data 0xBEEF, then 2'b11 at ram_addr 5 with data 0xDEAD, `cpu_ready` at cycle 3. A read of addr 0x0008 then gives `cpu_rdata`=0xDEADBEEF with `cpu_ready` at cycle 4.
- Byte write (continues from the previous scenario): wstrb=4'b0100, wdata 0x00AA0000 at 0x0008. Required: LO `ram_we`=00, HI `ram_we`=01; readback gives 0xDEAABEEF.
- Back-to-back: write, then read issued the cycle after ACK. Required: the read is accepted with no idle gap beyond the mandatory IDLE cycle, `cpu_rdata` is unchanged by the write, and exactly one `cpu_ready` pulse per request.
- Wrap: with ADDRESS_WIDTH=14, a write to byte addr 0x7FFC gives ram_addr 0x3FFE then 0x3FFF, and readback succeeds.
- Reset asserted during HI of a read: `cpu_ready` stays 0, state returns to IDLE and `cpu_rdata`=0. The next request completes normally.
